vrf_wport_arbiter: RTL
======================

// Module: vrf_wport_arbiter
// PURPOSE
//  Shares the W_PORTS_NUM write ports of the lane VRF among N_REQ write requesters (ALU, MUL, load, slide...).
//  Each cycle it grants up to W_PORTS_NUM requests round-robin and never grants two writes to one address in the same cycle.
//  Granted writes leave on registered port outputs that drive VRF waddr_i/bwe_i/din_i directly.
//  An in-flight scoreboard reports read-after-write hazards for addresses still inside the VRF write pipeline.
// PARAMETERS
//  N_REQ        6    number of write requesters
//  W_PORTS_NUM  4    VRF write ports; 1..N_REQ
//  MEM_DEPTH    512  VRF depth; AW = $clog2(MEM_DEPTH)
//  MEM_WIDTH    32   data width; NB = MEM_WIDTH/8 (min 1)
//  WR_LAT       2    cycles from port output to data readable in VRF (1..4)
//  HZ_PORTS     8    hazard query ports (one per VRF read port)
// PORTS
//  clk          in   1              clock
//  rstn         in   1              sync active-low reset
//  stall_i      in   1              1 = grant nothing this cycle
//  req_valid_i  in   N_REQ          write request valid
//  req_ready_o  out  N_REQ          grant; transfer when valid&ready (combinational)
//  req_waddr_i  in   N_REQ x AW     write address
//  req_bwe_i    in   N_REQ x NB     byte write enables
//  req_din_i    in   N_REQ x MEM_WIDTH  write data
//  waddr_o      out  W_PORTS_NUM x AW   to VRF waddr_i
//  bwe_o        out  W_PORTS_NUM x NB   to VRF bwe_i; 0 = port idle
//  din_o        out  W_PORTS_NUM x MEM_WIDTH  to VRF din_i
//  hz_raddr_i   in   HZ_PORTS x AW  read address to check
//  hz_hit_o     out  HZ_PORTS       1 = address has a write in flight
//  conflict_o   out  1              pulse: a request was deferred for address clash
// BEHAVIOUR
//  - Reset: waddr_o/bwe_o/din_o = 0, hz_hit_o = 0, conflict_o = 0, rr_ptr = 0, scoreboard cleared; req_ready_o = 0 while !rstn.
//  - Scan: requesters visited in order rr_ptr, rr_ptr+1, ... mod N_REQ; a valid one is granted if ports remain and its waddr differs from every address already granted this cycle.
//  - Port mapping: k-th grant of the cycle uses port k; unused ports get bwe_o = 0 (waddr_o/din_o hold previous value).
//  - Request with req_bwe_i == 0 is still granted (consumes port, no write).
//  - Latency: grant in cycle t -> port outputs valid in cycle t+1; 1 registered stage.
//  - rr_ptr update: first requester skipped for address clash if any; else one past last granted; unchanged if no grants or stall_i.
//  - Fairness: with no clashes every continuously valid requester is granted within ceil(N_REQ/W_PORTS_NUM) cycles.
//  - conflict_o = 1 the cycle after any clash-deferral.
//  - stall_i = 1: req_ready_o = 0, next-cycle bwe_o = 0, scoreboard still ages.
//  - Scoreboard: shift register of WR_LAT+1 stages holding each cycle's granted {addr, valid}.
//    hz_hit_o[i] is combinational: 1 if hz_raddr_i[i] matches any valid entry, including grants this cycle.
//  - Reset mid-operation: granted-but-not-yet-output writes are dropped; no partial port output.
// STRUCTURE
//  - vrf_pkg: AW/NB derivation functions, wport_req_t {waddr, bwe, din}, WR_LAT default constant.
//  - Sub-module vrf_rr_picker: rotate-from-pointer priority scan with address-clash mask, returning grant vector, port index per grant and next rr_ptr.
//    Purely combinational.
//  - Top level: input mux to ports, output registers, scoreboard shift register, hazard comparators.
// TESTING
//  - Reset: hold rstn=0 5 cycles with all valid -> all ready 0, bwe_o 0, hz_hit_o 0.
//  - 6 requesters valid, distinct addr, W=4 -> cycle0 grants 0-3 on ports 0-3; cycle1 grants 4,5,0,1; rr_ptr returns to 2.
//  - Req1, req3 both addr 0x10 -> req1 granted port0, req3 deferred, conflict_o=1 next cycle; req3 granted following cycle.
//  - stall_i=1 for 3 cycles with all valid -> no ready, bwe_o=0; after release grants resume from unchanged rr_ptr.
//  - Grant addr 0x42 at t, hz_raddr_i=0x42 -> hz_hit_o=1 cycles t..t+WR_LAT; 0 at t+WR_LAT+1.
//  - Random traffic vs. scoreboard model: each accepted write appears exactly once on a port.
//    No duplicate address in one cycle; final VRF model matches.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared sizing helpers, defaults and the write-request record for the lane
// VRF write path.
package vrf_pkg;

  localparam int DEF_MEM_DEPTH = 512;
  localparam int DEF_MEM_WIDTH = 32;
  localparam int DEF_WR_LAT    = 2;

  // Address width for a VRF of the given depth (at least one bit).
  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Byte-enable count for the given data width (at least one lane).
  function automatic int calc_nb(input int width);
    return ((width / 8) > 0) ? (width / 8) : 1;
  endfunction

  // Index width able to address n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_AW = calc_aw(DEF_MEM_DEPTH);
  localparam int DEF_NB = calc_nb(DEF_MEM_WIDTH);

  // One write request as seen by a VRF write port in the default geometry.
  typedef struct packed {
    logic [DEF_AW-1:0]        waddr;
    logic [DEF_NB-1:0]        bwe;
    logic [DEF_MEM_WIDTH-1:0] din;
  } wport_req_t;

endpackage

// File: rtl/vrf_rr_picker.sv
// Rotating-priority picker: visits requesters from rr_ptr onward, grants up
// to W_PORTS_NUM of them, and defers any whose address is already granted in
// the same cycle. Purely combinational.
module vrf_rr_picker
  import vrf_pkg::*;
#(
  parameter int N_REQ       = 6,
  parameter int W_PORTS_NUM = 4,
  parameter int AW          = 9,
  localparam int IW         = idx_w(N_REQ),
  localparam int PW         = idx_w(W_PORTS_NUM)
) (
  input  logic                     en,
  input  logic [N_REQ-1:0]         valid,
  input  logic [N_REQ-1:0][AW-1:0] waddr,
  input  logic [IW-1:0]            rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0][PW-1:0] port_idx,
  output logic                     clash,
  output logic [IW-1:0]            next_ptr
);

  logic [AW-1:0] taken_s [W_PORTS_NUM];
  int            cnt_s;
  logic [IW-1:0] idx_s;
  logic [IW-1:0] last_s;
  logic [IW-1:0] clash_idx_s;
  logic          any_grant_s;
  logic          match_s;

  // Requester index base+ofs modulo N_REQ; base < N_REQ and ofs <= N_REQ.
  function automatic logic [IW-1:0] wrap_idx(input int base, input int ofs);
    int sum;
    sum = base + ofs;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return IW'(sum);
  endfunction

  // Scan requesters in rotated order, granting ports and recording clashes.
  always_comb begin
    grant       = '0;
    port_idx    = '0;
    clash       = 1'b0;
    next_ptr    = rr_ptr;
    cnt_s       = 0;
    idx_s       = rr_ptr;
    last_s      = rr_ptr;
    clash_idx_s = rr_ptr;
    any_grant_s = 1'b0;
    match_s     = 1'b0;
    for (int j = 0; j < W_PORTS_NUM; j++) begin
      taken_s[j] = '0;
    end
    for (int i = 0; i < N_REQ; i++) begin
      idx_s   = wrap_idx(int'(rr_ptr), i);
      match_s = 1'b0;
      for (int j = 0; j < W_PORTS_NUM; j++) begin
        match_s = match_s | ((j < cnt_s) && (taken_s[j] == waddr[idx_s]));
      end
      if (en && valid[idx_s] && (cnt_s < W_PORTS_NUM)) begin
        if (match_s) begin
          // Only the first deferred requester steers the pointer.
          if (!clash) begin
            clash_idx_s = idx_s;
          end else begin
            clash_idx_s = clash_idx_s;
          end
          clash = 1'b1;
        end else begin
          grant[idx_s]    = 1'b1;
          port_idx[idx_s] = PW'(cnt_s);
          for (int j = 0; j < W_PORTS_NUM; j++) begin
            taken_s[j] = (j == cnt_s) ? waddr[idx_s] : taken_s[j];
          end
          cnt_s       = cnt_s + 1;
          last_s      = idx_s;
          any_grant_s = 1'b1;
        end
      end else begin
        cnt_s = cnt_s;
      end
    end
    // A deferred requester gets first pick next cycle; otherwise rotate past
    // the last winner; with no grants the pointer stays put.
    if (clash) begin
      next_ptr = clash_idx_s;
    end else if (any_grant_s) begin
      next_ptr = wrap_idx(int'(last_s), 1);
    end else begin
      next_ptr = rr_ptr;
    end
  end

endmodule

// File: rtl/vrf_wport_arbiter.sv
// Lane VRF write-port arbiter: shares W_PORTS_NUM registered write ports
// among N_REQ requesters and flags reads that hit writes still in flight.
module vrf_wport_arbiter
  import vrf_pkg::*;
#(
  parameter int N_REQ       = 6,
  parameter int W_PORTS_NUM = 4,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int MEM_WIDTH   = DEF_MEM_WIDTH,
  parameter int WR_LAT      = DEF_WR_LAT,
  parameter int HZ_PORTS    = 8,
  localparam int AW         = calc_aw(MEM_DEPTH),
  localparam int NB         = calc_nb(MEM_WIDTH),
  localparam int IW         = idx_w(N_REQ),
  localparam int PW         = idx_w(W_PORTS_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 stall_i,
  input  logic [N_REQ-1:0]                     req_valid_i,
  output logic [N_REQ-1:0]                     req_ready_o,
  input  logic [N_REQ-1:0][AW-1:0]             req_waddr_i,
  input  logic [N_REQ-1:0][NB-1:0]             req_bwe_i,
  input  logic [N_REQ-1:0][MEM_WIDTH-1:0]      req_din_i,
  output logic [W_PORTS_NUM-1:0][AW-1:0]       waddr_o,
  output logic [W_PORTS_NUM-1:0][NB-1:0]       bwe_o,
  output logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0] din_o,
  input  logic [HZ_PORTS-1:0][AW-1:0]          hz_raddr_i,
  output logic [HZ_PORTS-1:0]                  hz_hit_o,
  output logic                                 conflict_o
);

  logic                               en_s;
  logic [N_REQ-1:0]                   grant_s;
  logic [N_REQ-1:0][PW-1:0]           port_idx_s;
  logic                               clash_s;
  logic [IW-1:0]                      next_ptr_s;
  logic [IW-1:0]                      rr_ptr_r;

  logic                               pick_s;
  logic [W_PORTS_NUM-1:0]             sel_vld_s;
  logic [W_PORTS_NUM-1:0][AW-1:0]     sel_addr_s;
  logic [W_PORTS_NUM-1:0][NB-1:0]     sel_bwe_s;
  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0] sel_din_s;

  logic [W_PORTS_NUM-1:0][AW-1:0]     waddr_r;
  logic [W_PORTS_NUM-1:0][NB-1:0]     bwe_r;
  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0] din_r;
  logic                               conflict_r;

  // Scoreboard stage s holds the grants made s+1 cycles ago; the current
  // cycle's grants come straight from the port mux.
  logic [W_PORTS_NUM-1:0]             sb_vld_r  [WR_LAT];
  logic [W_PORTS_NUM-1:0][AW-1:0]     sb_addr_r [WR_LAT];
  logic                               hit_s;

  // Nothing is granted while in reset or stalled.
  assign en_s        = rstn & ~stall_i;
  assign req_ready_o = grant_s;

  vrf_rr_picker #(
    .N_REQ       (N_REQ),
    .W_PORTS_NUM (W_PORTS_NUM),
    .AW          (AW)
  ) u_picker (
    .en       (en_s),
    .valid    (req_valid_i),
    .waddr    (req_waddr_i),
    .rr_ptr   (rr_ptr_r),
    .grant    (grant_s),
    .port_idx (port_idx_s),
    .clash    (clash_s),
    .next_ptr (next_ptr_s)
  );

  // Steer each granted request onto the port chosen by the picker.
  always_comb begin
    pick_s     = 1'b0;
    sel_vld_s  = '0;
    sel_addr_s = '0;
    sel_bwe_s  = '0;
    sel_din_s  = '0;
    for (int k = 0; k < W_PORTS_NUM; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        pick_s        = grant_s[i] && (port_idx_s[i] == PW'(k));
        sel_vld_s[k]  = sel_vld_s[k] | pick_s;
        sel_addr_s[k] = sel_addr_s[k] | ({AW{pick_s}} & req_waddr_i[i]);
        sel_bwe_s[k]  = sel_bwe_s[k] | ({NB{pick_s}} & req_bwe_i[i]);
        sel_din_s[k]  = sel_din_s[k] | ({MEM_WIDTH{pick_s}} & req_din_i[i]);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_r <= '0;
    end else begin
      rr_ptr_r <= next_ptr_s;
    end
  end

  // Port output registers; idle ports drop bwe and keep address/data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      waddr_r    <= '0;
      bwe_r      <= '0;
      din_r      <= '0;
      conflict_r <= 1'b0;
    end else begin
      conflict_r <= clash_s;
      for (int k = 0; k < W_PORTS_NUM; k++) begin
        bwe_r[k] <= sel_vld_s[k] ? sel_bwe_s[k] : '0;
        if (sel_vld_s[k]) begin
          waddr_r[k] <= sel_addr_s[k];
          din_r[k]   <= sel_din_s[k];
        end
      end
    end
  end

  // In-flight scoreboard: shift each cycle's grants down the pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < WR_LAT; s++) begin
        sb_vld_r[s]  <= '0;
        sb_addr_r[s] <= '0;
      end
    end else begin
      sb_vld_r[0]  <= sel_vld_s;
      sb_addr_r[0] <= sel_addr_s;
      for (int s = 1; s < WR_LAT; s++) begin
        sb_vld_r[s]  <= sb_vld_r[s-1];
        sb_addr_r[s] <= sb_addr_r[s-1];
      end
    end
  end

  // Hazard compare against this cycle's grants and every scoreboard stage.
  always_comb begin
    hit_s    = 1'b0;
    hz_hit_o = '0;
    for (int h = 0; h < HZ_PORTS; h++) begin
      hit_s = 1'b0;
      for (int k = 0; k < W_PORTS_NUM; k++) begin
        hit_s = hit_s | (sel_vld_s[k] && (sel_addr_s[k] == hz_raddr_i[h]));
        for (int s = 0; s < WR_LAT; s++) begin
          hit_s = hit_s | (sb_vld_r[s][k] && (sb_addr_r[s][k] == hz_raddr_i[h]));
        end
      end
      hz_hit_o[h] = hit_s;
    end
  end

  assign waddr_o    = waddr_r;
  assign bwe_o      = bwe_r;
  assign din_o      = din_r;
  assign conflict_o = conflict_r;

endmodule
